// File: rtl/anubis_dec_key_reverser.sv
// Reorders an Anubis encryption round-key schedule K^0..K^R into the decryption
// schedule: outer keys swapped raw, middle keys reversed and passed through theta.
module anubis_dec_key_reverser #(
    parameter int MAX_ROUNDS = 18,
    parameter int MIN_ROUNDS = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [4:0]   num_rounds,
    input  logic         wr_valid,
    output logic         wr_ready,
    input  logic [127:0] wr_key,
    output logic         rd_valid,
    input  logic         rd_ready,
    output logic [127:0] rd_key,
    output logic         rd_last,
    output logic         busy
);

    localparam int DEPTH = MAX_ROUNDS + 1;

    typedef enum logic [1:0] {IDLE, LOAD, EMIT} state_e;

    state_e         state_q, state_d;
    logic [4:0]     r_q, r_d;
    logic [4:0]     wcnt_q, wcnt_d;
    logic [4:0]     jcnt_q, jcnt_d;
    logic           rd_valid_q, rd_valid_d;
    logic [127:0]   rd_key_q, rd_key_d;
    logic           rd_last_q, rd_last_d;
    logic [127:0]   key_mem [DEPTH];

    logic           num_ok;
    logic           wr_fire;
    logic           rd_fire;
    logic [4:0]     jcnt_nxt;
    logic [4:0]     mid_idx;
    logic [4:0]     wr_idx;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1D : 8'h00);
    endfunction

    // Multiply by h[sel] where h = {01,02,04,06}.
    function automatic logic [7:0] mul_h(input logic [7:0] a, input logic [1:0] sel);
        logic [7:0] x2;
        logic [7:0] x4;
        x2 = xtime(a);
        x4 = xtime(x2);
        case (sel)
            2'd0:    return a;
            2'd1:    return x2;
            2'd2:    return x4;
            default: return x4 ^ x2;
        endcase
    endfunction

    function automatic logic [127:0] theta(input logic [127:0] a);
        logic [127:0] b;
        logic [7:0]   acc;
        b = '0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                acc = '0;
                for (int k = 0; k < 4; k++) begin
                    acc ^= mul_h(a[127-8*(4*i+k) -: 8], 2'(k ^ j));
                end
                b[127-8*(4*i+j) -: 8] = acc;
            end
        end
        return b;
    endfunction

    assign num_ok   = (num_rounds >= 5'(MIN_ROUNDS)) && (num_rounds <= 5'(MAX_ROUNDS));
    assign wr_fire  = wr_valid && wr_ready;
    assign rd_fire  = rd_valid_q && rd_ready;
    assign jcnt_nxt = jcnt_q + 5'd1;
    assign mid_idx  = r_q - jcnt_nxt;
    assign wr_idx   = (state_q == IDLE) ? 5'd0 : wcnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            r_q        <= '0;
            wcnt_q     <= '0;
            jcnt_q     <= '0;
            rd_valid_q <= 1'b0;
            rd_key_q   <= '0;
            rd_last_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            r_q        <= r_d;
            wcnt_q     <= wcnt_d;
            jcnt_q     <= jcnt_d;
            rd_valid_q <= rd_valid_d;
            rd_key_q   <= rd_key_d;
            rd_last_q  <= rd_last_d;
        end
    end

    // Key store is deliberately left uncleared by reset.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            key_mem[wr_idx] <= wr_key;
        end
    end

    always_comb begin
        state_d    = state_q;
        r_d        = r_q;
        wcnt_d     = wcnt_q;
        jcnt_d     = jcnt_q;
        rd_valid_d = rd_valid_q;
        rd_key_d   = rd_key_q;
        rd_last_d  = rd_last_q;
        case (state_q)
            IDLE: begin
                if (wr_fire) begin
                    r_d     = num_rounds;
                    wcnt_d  = 5'd1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (wr_fire) begin
                    wcnt_d = wcnt_q + 5'd1;
                    // The final key K^R is also the first output, taken straight off the bus.
                    if (wcnt_q == r_q) begin
                        state_d    = EMIT;
                        jcnt_d     = '0;
                        rd_valid_d = 1'b1;
                        rd_key_d   = wr_key;
                        rd_last_d  = 1'b0;
                    end
                end
            end
            EMIT: begin
                if (rd_fire) begin
                    if (rd_last_q) begin
                        state_d    = IDLE;
                        rd_valid_d = 1'b0;
                        rd_last_d  = 1'b0;
                        wcnt_d     = '0;
                        jcnt_d     = '0;
                    end else begin
                        jcnt_d    = jcnt_nxt;
                        rd_last_d = (jcnt_nxt == r_q);
                        rd_key_d  = (jcnt_nxt == r_q) ? key_mem[0] : theta(key_mem[mid_idx]);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_ready = 1'b0;
        case (state_q)
            IDLE:    wr_ready = num_ok && !rst;
            LOAD:    wr_ready = !rst;
            default: wr_ready = 1'b0;
        endcase
        busy = (state_q != IDLE);
    end

    assign rd_valid = rd_valid_q;
    assign rd_key   = rd_key_q;
    assign rd_last  = rd_last_q;

endmodule

// File: tb/tb_anubis_dec_key_reverser.sv
// Bench for anubis_dec_key_reverser: known-answer vectors plus random schedules
// checked against a GF(2^8) matrix model of the reversed key order.
module tb_anubis_dec_key_reverser;

    localparam int MAXR = 18;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [4:0]   num_rounds = '0;
    logic         wr_valid = 1'b0;
    logic         wr_ready;
    logic [127:0] wr_key = '0;
    logic         rd_valid;
    logic         rd_ready = 1'b0;
    logic [127:0] rd_key;
    logic         rd_last;
    logic         busy;

    int checks = 0;
    int errors = 0;

    logic [127:0] sched   [MAXR+1];
    logic [127:0] exp_key [MAXR+1];
    logic [127:0] cap_key [MAXR+1];
    logic         cap_last[MAXR+1];

    typedef struct {
        int           test_id;
        int           j;
        logic [127:0] key;
        logic         last;
    } vec_t;

    vec_t vecs[8];

    anubis_dec_key_reverser #(.MAX_ROUNDS(18), .MIN_ROUNDS(12)) dut (
        .clk        (clk),
        .rst        (rst),
        .num_rounds (num_rounds),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_key     (wr_key),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .rd_key     (rd_key),
        .rd_last    (rd_last),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        int p;
        p = 0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (int'(a) << i);
        for (int bitn = 15; bitn >= 8; bitn--) if (p[bitn]) p = p ^ (32'h11D << (bitn - 8));
        return p[7:0];
    endfunction

    function automatic logic [127:0] theta_ref(input logic [127:0] a);
        logic [7:0]   h [4];
        logic [7:0]   m [4][4];
        logic [127:0] b;
        logic [7:0]   acc;
        h = '{8'h01, 8'h02, 8'h04, 8'h06};
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                m[i][j] = a[127-8*(4*i+j) -: 8];
        b = '0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                acc = '0;
                for (int k = 0; k < 4; k++) acc = acc ^ gf_mul(m[i][k], h[k ^ j]);
                b[127-8*(4*i+j) -: 8] = acc;
            end
        return b;
    endfunction

    task automatic buildModel(input int r);
        for (int j = 0; j <= r; j++) begin
            if (j == 0)      exp_key[j] = sched[r];
            else if (j == r) exp_key[j] = sched[0];
            else             exp_key[j] = theta_ref(sched[r-j]);
        end
    endtask

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    // Writes the first n keys of sched with R=r, randomly scrambling num_rounds mid-load.
    task automatic applyStimulus(input int r, input int n, input bit gaps);
        int idx;
        int budget;
        idx = 0;
        budget = 0;
        num_rounds = 5'(r);
        while (idx < n && budget < 1000) begin
            @(negedge clk);
            wr_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            wr_key = sched[idx];
            if (idx > 0) num_rounds = 5'($urandom_range(0, 31));
            #1;
            checkOutput("wr_ready_load", 128'(wr_ready), 128'd1);
            if (wr_valid && wr_ready) idx++;
            budget++;
        end
        if (idx < n) checkOutput("write_timeout", 128'(idx), 128'(n));
    endtask

    // Reads n outputs; mode 1 toggles rd_ready randomly and stalls 5 cycles at j=7.
    task automatic readSchedule(input int r, input int n, input int mode);
        int j;
        int budget;
        int stall;
        bit first;
        j = 0;
        budget = 0;
        stall = 0;
        first = 1'b1;
        for (int i = 0; i <= MAXR; i++) begin
            cap_key[i] = '0;
            cap_last[i] = 1'b0;
        end
        while (j < n && budget < 1000) begin
            @(negedge clk);
            wr_valid = 1'($urandom_range(0, 1));
            wr_key = {$urandom(), $urandom(), $urandom(), $urandom()};
            if (mode == 0) rd_ready = 1'b1;
            else if (j == 7 && stall < 5) begin
                rd_ready = 1'b0;
                stall++;
            end else rd_ready = 1'($urandom_range(0, 1));
            #1;
            if (first) begin
                checkOutput("latency_rd_valid", 128'(rd_valid), 128'd1);
                first = 1'b0;
            end
            checkOutput("wr_ready_emit", 128'(wr_ready), 128'd0);
            checkOutput("busy_emit", 128'(busy), 128'd1);
            if (rd_valid) begin
                checkOutput($sformatf("rd_key_j%0d", j), rd_key, exp_key[j]);
                checkOutput($sformatf("rd_last_j%0d", j), 128'(rd_last), 128'(j == r));
                cap_key[j] = rd_key;
                cap_last[j] = rd_last;
                if (rd_ready) j++;
            end
            budget++;
        end
        if (j < n) checkOutput("read_timeout", 128'(j), 128'(n));
        if (n == r + 1) begin
            @(negedge clk);
            wr_valid = 1'b0;
            rd_ready = 1'b0;
            #1;
            checkOutput("rd_valid_after", 128'(rd_valid), 128'd0);
            checkOutput("busy_after", 128'(busy), 128'd0);
            checkOutput("rd_last_after", 128'(rd_last), 128'd0);
        end
    endtask

    task automatic runFull(input int r, input bit gaps, input int mode);
        buildModel(r);
        applyStimulus(r, r + 1, gaps);
        readSchedule(r, r + 1, mode);
    endtask

    task automatic checkTable(input int test_id);
        foreach (vecs[v]) begin
            if (vecs[v].test_id == test_id) begin
                checkOutput($sformatf("vec_t%0d_j%0d_key", test_id, vecs[v].j), cap_key[vecs[v].j], vecs[v].key);
                checkOutput($sformatf("vec_t%0d_j%0d_last", test_id, vecs[v].j), 128'(cap_last[vecs[v].j]), 128'(vecs[v].last));
            end
        end
    endtask

    task automatic randomSched(input int r);
        for (int i = 0; i <= r; i++) sched[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_busy"}, 128'(busy), 128'd0);
        checkOutput({tag, "_rd_valid"}, 128'(rd_valid), 128'd0);
        checkOutput({tag, "_rd_key"}, rd_key, 128'd0);
        checkOutput({tag, "_rd_last"}, 128'(rd_last), 128'd0);
    endtask

    initial begin
        vecs[0] = '{0, 0,  {8'h0C, 120'h0}, 1'b0};
        vecs[1] = '{0, 1,  {32'h0B162C3A, 96'h0}, 1'b0};
        vecs[2] = '{0, 5,  {32'h070E1C12, 96'h0}, 1'b0};
        vecs[3] = '{0, 11, {32'h01020406, 96'h0}, 1'b0};
        vecs[4] = '{0, 12, 128'h0, 1'b1};
        vecs[5] = '{1, 1,  {32'h801D3A27, 96'h0}, 1'b0};
        vecs[6] = '{2, 0,  {16{8'h5A}}, 1'b0};
        vecs[7] = '{2, 5,  {16{8'h5A}}, 1'b0};

        num_rounds = 5'd12;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checkResetValues("reset");
        checkOutput("reset_wr_ready", 128'(wr_ready), 128'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i <= 12; i++) sched[i] = {8'(i), 120'h0};
        runFull(12, 1'b0, 0);
        checkTable(0);

        for (int i = 0; i <= 12; i++) sched[i] = {8'(i), 120'h0};
        sched[11] = {8'h80, 120'h0};
        runFull(12, 1'b0, 0);
        checkTable(1);

        for (int i = 0; i <= 12; i++) sched[i] = {16{8'h5A}};
        runFull(12, 1'b1, 1);
        checkTable(2);

        randomSched(18);
        runFull(18, 1'b1, 1);

        @(negedge clk);
        wr_valid = 1'b1;
        wr_key = {$urandom(), $urandom(), $urandom(), $urandom()};
        for (int t = 0; t < 6; t++) begin
            num_rounds = (t < 3) ? 5'd11 : 5'd19;
            @(negedge clk);
            #1;
            checkOutput($sformatf("invalid_r_wr_ready_%0d", t), 128'(wr_ready), 128'd0);
            checkOutput($sformatf("invalid_r_busy_%0d", t), 128'(busy), 128'd0);
            checkOutput($sformatf("invalid_r_rd_valid_%0d", t), 128'(rd_valid), 128'd0);
        end
        wr_valid = 1'b0;
        randomSched(12);
        runFull(12, 1'b1, 0);

        randomSched(12);
        applyStimulus(12, 7, 1'b1);
        @(negedge clk);
        wr_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        #1;
        checkResetValues("rst_load");
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            #1;
            checkOutput("rst_load_no_emit", 128'(rd_valid), 128'd0);
        end

        randomSched(12);
        buildModel(12);
        applyStimulus(12, 13, 1'b0);
        readSchedule(12, 4, 0);
        @(negedge clk);
        rd_ready = 1'b0;
        wr_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        #1;
        checkResetValues("rst_emit");
        rst = 1'b0;

        randomSched(12);
        runFull(12, 1'b1, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/anubis_dec_key_reverser.md
Name: anubis_dec_key_reverser

Overview:
- Sequential key-schedule companion that converts an Anubis encryption round-key sequence into the decryption sequence.
- Accepts K^0..K^R in order and emits K'^0..K'^R with K'^0 = K^R, K'^j = theta(K^(R-j)) for 0<j<R, and K'^R = K^0.
- Sits between the encryption key expander and the round datapath when the core runs in decrypt mode.
- The gamma layer is an involution and needs no counterpart; theta on the middle keys is what makes the round keys direction-specific.

Parameters:
- MAX_ROUNDS, 18, largest supported R; key store depth is MAX_ROUNDS+1 entries of 128 bits.
- MIN_ROUNDS, 12, smallest accepted R.

Ports:
- clk  input  1  clock, all logic rising-edge.
- rst  input  1  synchronous, active-high reset.
- num_rounds  input  5  R for the next schedule; sampled only on the first accepted write of a load.
- wr_valid  input  1  wr_key holds a valid encryption round key.
- wr_ready  output  1  block accepts wr_key this cycle.
- wr_key  input  128  encryption round key K^r, presented in order r = 0..R.
- rd_valid  output  1  rd_key holds a valid decryption round key.
- rd_ready  input  1  consumer accepts rd_key this cycle.
- rd_key  output  128  decryption round key K'^j, j = 0..R.
- rd_last  output  1  high with rd_valid when j = R.
- busy  output  1  high in LOAD and EMIT.

Behaviour:
- Reset is synchronous and active-high. Clock is clk, reset is rst.
- Reset values: wr_ready=0, rd_valid=0, rd_key=0, rd_last=0, busy=0. State=IDLE, counters=0, latched R=0.
- Key store contents are not cleared by reset.

Byte map and theta:
- State byte a[i][j] = bits [127-8*(4i+j) -: 8], row-major.
- theta: b[i][j] = XOR over k of a[i][k]*H[k][j], with H[k][j] = h[k^j] and h = {01,02,04,06}.
- Arithmetic is GF(2^8) with reduction polynomial 0x11D. theta is combinational and an involution.

Handshake:
- Write transfer occurs when wr_valid && wr_ready.
- Read transfer occurs when rd_valid && rd_ready.
- rd_key and rd_last stay stable while rd_valid && !rd_ready.

FSM:
- IDLE:
  - wr_ready=1 only if MIN_ROUNDS <= num_rounds <= MAX_ROUNDS; otherwise wr_ready=0 and all writes are ignored.
  - On a write transfer: latch R=num_rounds, store wr_key at index 0, set wcnt=1, go to LOAD.
- LOAD:
  - wr_ready=1. Each transfer stores at index wcnt, then wcnt++.
  - On the transfer with wcnt==R: go to EMIT, set jcnt=0, and register rd_key=K^R with rd_valid=1 on the next edge.
  - Latency: rd_valid rises exactly 1 cycle after the final write transfer.
- EMIT:
  - wr_ready=0. rd_key is registered and selected by jcnt.
  - jcnt=0 gives raw store[R]. 0<jcnt<R gives theta(store[R-jcnt]). jcnt=R gives raw store[0] with rd_last=1.
  - On each read transfer jcnt++ and the next key is registered the same edge, so back-to-back reads sustain 1 key/cycle.
  - On the transfer with rd_last=1: rd_valid=0, rd_last=0, go to IDLE. busy drops the same edge.
  - wr_ready stays 0 during the cycle rd_valid falls; new loads start from IDLE the next cycle.

Boundary conditions:
- num_rounds changes mid-load: ignored, R stays latched.
- wr_valid during EMIT: ignored (wr_ready=0).
- rd_ready stalls of any length are allowed and drop no data.
- rst asserted in LOAD or EMIT: next edge is IDLE with reset output values. A partial schedule is discarded and never emitted.
- R=MAX_ROUNDS: uses all MAX_ROUNDS+1 entries, no wrap. Indices never exceed R.

Test Plan:
- theta check, R=12, K^r = {r[7:0],120'h0}, r=0..12, rd_ready=1:
  - Output count is 13, cycle after 13th write.
  - rd_key j=0 = 128'h0C00..00.
  - j=1 = 128'h0B162C3A_00000000_00000000_00000000.
  - j=11 = 128'h01020406_00..00.
  - j=12 = 128'h0, with rd_last=1 only there.
- GF reduction: R=12, K^11 = {8'h80,120'h0}. j=1 = 128'h801D3A27_00..00.
- Involution/row-constant: all keys = 128'h5A repeated 16 bytes. Every rd_key = same value; theta of a constant row is identity.
- Backpressure, R=18:
  - Random wr_valid gaps and rd_ready toggling (stall 5 cycles at j=7).
  - rd_key holds during the stall; 19 outputs emitted in order.
  - wr_ready=0 throughout EMIT.
- Invalid R: num_rounds=11, then 19 with wr_valid=1.
  - wr_ready=0, busy=0, no outputs.
  - Then num_rounds=12 is accepted.
- Reset mid-op:
  - Assert rst after 7 writes, then after 4 reads of a second load.
  - Next edge: busy=0, rd_valid=0, rd_key=0.
  - A subsequent full R=12 load emits the correct 13 keys.
